// File: rtl/blue_exec_unit.sv
// Blue execution unit: RA/RB register pair with a one-instruction valid/ready port,
// single-cycle ALU operations and iterative one-bit-per-cycle shifts.
module blue_exec_unit #(
  parameter int WIDTH = 16,
  parameter int INS_W = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [INS_W-1:0] ins,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] RA_OUT,
  output logic [WIDTH-1:0] RB_OUT,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             illegal,
  output logic             ld_err,
  output logic [1:0]       o_dbg_state
);

  // Handshake: an instruction transfers on a rising edge where ins_valid and
  // ins_ready are both high; ins is sampled only on that edge. ins_ready is
  // held low while busy and whenever a load is requested, so loads win.

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_MOV  = 4'd9;
  localparam logic [3:0] OP_EXCH = 4'd10;
  localparam logic [3:0] OP_SAR  = 4'd11;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_z;
  logic             r_c;
  logic             r_n;
  logic             r_shc;
  logic             r_done;
  logic             r_illegal;
  logic             r_ld_err;

  logic             w_ins_ready;
  logic             w_busy;
  logic             w_accept;
  logic             w_finish;
  logic [3:0]       w_ins_op;
  logic             w_ins_is_shift;
  logic             w_unused_ins;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_alu_ra;
  logic [WIDTH-1:0] w_alu_rb;
  logic             w_alu_c;
  logic             w_alu_ill;
  logic [WIDTH-1:0] w_sh_ra;
  logic             w_sh_out;

  assign w_ins_op       = ins[INS_W-1 -: 4];
  assign w_ins_is_shift = (w_ins_op == OP_SHR) || (w_ins_op == OP_SHL) ||
                          (w_ins_op == OP_ROR) || (w_ins_op == OP_SAR);
  assign w_unused_ins   = ^ins;
  assign w_accept       = ins_valid & w_ins_ready;
  assign w_finish       = (r_state == S_EXEC) || ((r_state == S_SHIFT) && (r_cnt == '0));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_ins_is_shift ? S_SHIFT : S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_IDLE;
      S_SHIFT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_ins_ready = 1'b0;
    w_busy      = 1'b1;
    if (r_state == S_IDLE) begin
      w_ins_ready = ~ld_a & ~ld_b;
      w_busy      = 1'b0;
    end
  end

  assign w_add = {1'b0, r_ra} + {1'b0, r_rb};
  assign w_sub = {1'b0, r_ra} - {1'b0, r_rb};

  // Retirement result; shift opcodes only retire from SHIFT, carrying the last bit out.
  always_comb begin
    w_alu_ra  = r_ra;
    w_alu_rb  = r_rb;
    w_alu_c   = 1'b0;
    w_alu_ill = 1'b0;
    case (r_op)
      OP_NOP:  ;
      OP_ADD:  begin w_alu_ra = w_add[WIDTH-1:0]; w_alu_c = w_add[WIDTH]; end
      OP_SUB:  begin w_alu_ra = w_sub[WIDTH-1:0]; w_alu_c = w_sub[WIDTH]; end
      OP_OR:   w_alu_ra = r_ra | r_rb;
      OP_AND:  w_alu_ra = r_ra & r_rb;
      OP_XOR:  w_alu_ra = r_ra ^ r_rb;
      OP_SHR, OP_SHL, OP_ROR, OP_SAR: w_alu_c = r_shc;
      OP_MOV:  w_alu_rb = r_ra;
      OP_EXCH: begin w_alu_ra = r_rb; w_alu_rb = r_ra; end
      default: w_alu_ill = 1'b1;
    endcase
  end

  // One-bit shift step
  always_comb begin
    w_sh_ra  = r_ra;
    w_sh_out = 1'b0;
    case (r_op)
      OP_SHR:  begin w_sh_ra = {1'b0, r_ra[WIDTH-1:1]};       w_sh_out = r_ra[0]; end
      OP_SAR:  begin w_sh_ra = {r_ra[WIDTH-1], r_ra[WIDTH-1:1]}; w_sh_out = r_ra[0]; end
      OP_ROR:  begin w_sh_ra = {r_ra[0], r_ra[WIDTH-1:1]};    w_sh_out = r_ra[0]; end
      OP_SHL:  begin w_sh_ra = {r_ra[WIDTH-2:0], 1'b0};       w_sh_out = r_ra[WIDTH-1]; end
      default: ;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_NOP;
      r_cnt     <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_n       <= 1'b0;
      r_shc     <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_ld_err  <= 1'b0;
    end else begin
      r_done    <= w_finish;
      r_illegal <= w_finish & w_alu_ill;
      r_ld_err  <= w_busy & (ld_a | ld_b);
      if (r_state == S_IDLE) begin
        if (ld_a) r_ra <= ld_data;
        if (ld_b) r_rb <= ld_data;
        if (w_accept) begin
          r_op  <= w_ins_op;
          r_cnt <= ins[SHW-1:0];
          r_shc <= 1'b0;
        end
      end else if (w_finish) begin
        r_ra <= w_alu_ra;
        r_rb <= w_alu_rb;
        r_z  <= (w_alu_ra == '0);
        r_c  <= w_alu_c;
        r_n  <= w_alu_ra[WIDTH-1];
      end else begin
        r_ra  <= w_sh_ra;
        r_shc <= w_sh_out;
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  assign ins_ready   = w_ins_ready;
  assign busy        = w_busy;
  assign RA_OUT      = r_ra;
  assign RB_OUT      = r_rb;
  assign flag_z      = r_z;
  assign flag_c      = r_c;
  assign flag_n      = r_n;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign ld_err      = r_ld_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_blue_exec_unit.sv
// Self-checking bench for blue_exec_unit: vector table plus hand sequences for
// load/instruction collisions, dropped loads during shifts and mid-shift reset.
module tb_blue_exec_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ins_valid;
  logic          ins_ready;
  logic [15:0]   ins;
  logic          ld_a;
  logic          ld_b;
  logic [W-1:0]  ld_data;
  logic [W-1:0]  RA_OUT;
  logic [W-1:0]  RB_OUT;
  logic          busy;
  logic          done;
  logic          flag_z;
  logic          flag_c;
  logic          flag_n;
  logic          illegal;
  logic          ld_err;
  logic [1:0]    o_dbg_state;

  blue_exec_unit #(.WIDTH(W), .INS_W(16), .SHW(4)) dut (
    .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins(ins), .ld_a(ld_a), .ld_b(ld_b), .ld_data(ld_data),
    .RA_OUT(RA_OUT), .RB_OUT(RB_OUT), .busy(busy), .done(done),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .illegal(illegal),
    .ld_err(ld_err), .o_dbg_state(o_dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   op;
    logic [3:0]   amt;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         ez;
    logic         ec;
    logic         en;
    logic         eil;
    logic [7:0]   lat;
  } vec_t;

  localparam int EXP_W = 2*W + 12;
  logic [EXP_W-1:0] exp_q[$];

  int n_applied = 0;
  int n_err     = 0;
  int acc_cyc   = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each retirement against the oldest expected entry
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (prev_done) begin
      chk("done_width", {31'd0, done}, 32'd0);
      chk("illegal_outside_done", {31'd0, illegal}, 32'd0);
    end
    prev_done = done;
    if (!reset && ins_valid && ins_ready) acc_cyc = cyc;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_applied++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no retirement (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("ra", {16'd0, RA_OUT}, {16'd0, e[EXP_W-1 -: W]});
        chk("rb", {16'd0, RB_OUT}, {16'd0, e[EXP_W-W-1 -: W]});
        chk("flag_z", {31'd0, flag_z}, {31'd0, e[11]});
        chk("flag_c", {31'd0, flag_c}, {31'd0, e[10]});
        chk("flag_n", {31'd0, flag_n}, {31'd0, e[9]});
        chk("illegal", {31'd0, illegal}, {31'd0, e[8]});
        chk("latency", cyc - acc_cyc, {24'd0, e[7:0]});
        chk("ready_in_done", {31'd0, ins_ready}, 32'd1);
      end
    end
  end

  task automatic wait_done();
    logic got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_applied++;
      n_err++;
      $display("FAIL timeout: got no done within 40 cycles expected done (t=%0t)", $time);
    end
  endtask

  task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    ld_a = 1'b1; ld_data = a;
    @(posedge clk); #1;
    ld_a = 1'b0; ld_b = 1'b1; ld_data = b;
    @(posedge clk); #1;
    ld_b = 1'b0; ld_data = W'($urandom_range(0, 65535));
  endtask

  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb,
                          input logic ez, input logic ec, input logic en,
                          input logic eil, input logic [7:0] lat);
    exp_q.push_back({ea, eb, ez, ec, en, eil, lat});
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] amt, input vec_t v);
    @(posedge clk); #1;
    ins_valid = 1'b1;
    ins = {op, 8'h00, amt};
    push_exp(v.ea, v.eb, v.ez, v.ec, v.en, v.eil, v.lat);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    ins = 16'($urandom_range(0, 65535));
    wait_done();
  endtask

  vec_t vecs[23];
  vec_t hv;

  initial begin
    vecs[0]  = '{4'd1,  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[1]  = '{4'd2,  4'd0,  16'h0003, 16'h0005, 16'hFFFE, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[2]  = '{4'd2,  4'd0,  16'h0005, 16'h0005, 16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[3]  = '{4'd1,  4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[4]  = '{4'd3,  4'd0,  16'h00F0, 16'h0F0F, 16'h0FFF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[5]  = '{4'd4,  4'd0,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[6]  = '{4'd5,  4'd0,  16'hFFFF, 16'h1234, 16'hEDCB, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[7]  = '{4'd6,  4'd4,  16'h8001, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6};
    vecs[8]  = '{4'd11, 4'd4,  16'h8001, 16'h0000, 16'hF800, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6};
    vecs[9]  = '{4'd7,  4'd1,  16'h8001, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[10] = '{4'd8,  4'd2,  16'h0003, 16'h0000, 16'hC000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};
    vecs[11] = '{4'd6,  4'd0,  16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[12] = '{4'd10, 4'd0,  16'h1234, 16'hABCD, 16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[13] = '{4'd9,  4'd0,  16'hABCD, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[14] = '{4'd0,  4'd0,  16'h0000, 16'h5555, 16'h0000, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[15] = '{4'd14, 4'd0,  16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[16] = '{4'd12, 4'd0,  16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[17] = '{4'd7,  4'd15, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd17};
    vecs[18] = '{4'd8,  4'd15, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd17};
    vecs[19] = '{4'd11, 4'd3,  16'h7FF0, 16'h0000, 16'h0FFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5};
    vecs[20] = '{4'd2,  4'd0,  16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[21] = '{4'd0,  4'd0,  16'h8000, 16'h1234, 16'h8000, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[22] = '{4'd15, 4'd5,  16'h0000, 16'h0001, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};

    // Reset
    reset = 1'b1; ins_valid = 1'b0; ins = '0; ld_a = 1'b0; ld_b = 1'b0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ra", {16'd0, RA_OUT}, 32'd0);
    chk("rst_rb", {16'd0, RB_OUT}, 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
    chk("rst_status", {28'd0, done, illegal, ld_err, busy}, 32'd0);
    chk("rst_ready", {31'd0, ins_ready}, 32'd1);

    // Load collides with an instruction: load wins, instruction goes next cycle
    @(posedge clk); #1;
    ld_a = 1'b1; ld_data = 16'h0010; ins_valid = 1'b1; ins = {4'd1, 12'h000};
    @(negedge clk);
    chk("ready_during_load", {31'd0, ins_ready}, 32'd0);
    @(posedge clk); #1;
    ld_a = 1'b0;
    @(negedge clk);
    chk("ra_loaded", {16'd0, RA_OUT}, 32'h0010);
    chk("ready_after_load", {31'd0, ins_ready}, 32'd1);
    push_exp(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    wait_done();

    // Vector table
    for (int i = 0; i < 23; i++) begin
      load_ab(vecs[i].a, vecs[i].b);
      issue(vecs[i].op, vecs[i].amt, vecs[i]);
    end

    // EXCH followed by MOV without reloading
    load_ab(16'h1234, 16'hABCD);
    hv = '{4'd10, 4'd0, 16'h0, 16'h0, 16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    issue(4'd10, 4'd0, hv);
    hv = '{4'd9, 4'd0, 16'h0, 16'h0, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    issue(4'd9, 4'd0, hv);

    // Load of RB during a shift is dropped and flagged
    load_ab(16'h8001, 16'h0077);
    @(posedge clk); #1;
    ins_valid = 1'b1; ins = {4'd6, 8'h00, 4'd4};
    push_exp(16'h0800, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6);
    @(posedge clk); #1;
    ins_valid = 1'b0; ld_b = 1'b1; ld_data = 16'hFFFF;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("shift_busy", {31'd0, busy}, 32'd1);
      chk("shift_not_ready", {31'd0, ins_ready}, 32'd0);
      if (i == 1) begin
        chk("ld_err_before", {31'd0, ld_err}, 32'd0);
        @(posedge clk); #1;
        ld_b = 1'b0;
      end
      if (i == 2) chk("ld_err_pulse", {31'd0, ld_err}, 32'd1);
      if (i == 3) chk("ld_err_clear", {31'd0, ld_err}, 32'd0);
    end
    wait_done();

    // Reset in the middle of SHL by 8
    load_ab(16'h00FF, 16'h1111);
    @(posedge clk); #1;
    ins_valid = 1'b1; ins = {4'd7, 8'h00, 4'd8};
    @(posedge clk); #1;
    ins_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_state", {30'd0, o_dbg_state}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ra", {16'd0, RA_OUT}, 32'd0);
    chk("abort_rb", {16'd0, RB_OUT}, 32'd0);
    begin
      int nd = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk("abort_no_done", nd, 32'd0);
    end

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
    $finish;
  end

endmodule

// File: doc/blue_exec_unit.md
Name: blue_exec_unit

Overview:
Parametrised, registered successor to the Blue two-register datapath. It holds RA/RB internally, accepts one instruction at a time over a valid/ready handshake, and executes it in one cycle. Multi-bit shifts run iteratively, one bit per cycle. It reports completion, Z/C/N flags and illegal-opcode status to the Blue sequencer, which issues instructions and preloads operands.

Parameters:
WIDTH, 16, data width of RA/RB.
INS_W, 16, instruction width; opcode is ins[INS_W-1:INS_W-4].
SHW, 4, shift-amount field width (ins[SHW-1:0]); must satisfy 2**SHW >= WIDTH.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous active-high reset.
ins_valid  in  1  instruction offered.
ins_ready  out  1  unit can accept an instruction this cycle.
ins  in  INS_W  instruction word.
ld_a  in  1  load ld_data into RA.
ld_b  in  1  load ld_data into RB.
ld_data  in  WIDTH  preload value.
RA_OUT  out  WIDTH  current RA register.
RB_OUT  out  WIDTH  current RB register.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse: instruction retired, results visible.
flag_z  out  1  retired RA result == 0.
flag_c  out  1  carry, borrow or last shifted-out bit.
flag_n  out  1  retired RA result MSB.
illegal  out  1  with done: retired opcode was illegal.
ld_err  out  1  one-cycle pulse: load dropped because busy.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: RA, RB, flags, done, illegal and ld_err all go to 0; state goes to IDLE; shift counter goes to 0. Reset mid-operation aborts the operation: no done, and partial shift results are discarded.
- ins_ready = (state==IDLE) & ~ld_a & ~ld_b (combinational). A load has priority over an instruction in the same cycle.
- Load in IDLE: at the edge, RA<=ld_data if ld_a and RB<=ld_data if ld_b. Both loads may fire together. Flags are unchanged and there is no done.
- Load while busy: dropped, and ld_err pulses in the following cycle.
- States:
  - IDLE: on handshake, latch ins. Shift opcodes go to SHIFT with cnt=ins[SHW-1:0]. All other opcodes go to EXEC.
  - EXEC: one cycle. RA/RB/flags update at the closing edge, state returns to IDLE, and done=1 in the next cycle.
  - SHIFT: if cnt==0, finish as in EXEC. Otherwise shift RA by 1, set C to the bit shifted out, and decrement cnt.
- Latency:
  - Non-shift instruction accepted at edge k: results and done are visible after edge k+1.
  - Shift by n: results and done are visible after edge k+n+1.
  - Next accept is possible in the done cycle, since ins_ready=1 there.
- Opcodes (all arithmetic is modulo 2**WIDTH):
  - 0 NOP: no register change; flags recomputed from RA, C=0.
  - 1 ADD: RA<=RA+RB, C=carry out.
  - 2 SUB: RA<=RA-RB, C=borrow (RA<RB unsigned).
  - 3 OR, 4 AND, 5 XOR: RA<=RA op RB, C=0.
  - 6 SHR: logical right shift by amt, zero fill.
  - 7 SHL: logical left shift by amt.
  - 8 ROR: rotate right by amt; C=last bit rotated.
  - 9 MOV: RB<=RA, RA unchanged, C=0.
  - 10 EXCH: RA<=RB, RB<=RA simultaneously, C=0.
  - 11 SAR: arithmetic right shift, sign fill.
  - 12-15: illegal. Registers unchanged, C=0, done=1 with illegal=1.
- Z/N are computed from the new RA for every retired instruction, including MOV and illegal.
- Shift amount 0: RA unchanged, C=0, latency identical to EXEC.
- illegal is valid only with done; it is 0 otherwise.
- ins is sampled only at the handshake; changes afterward are ignored.

Test Plan:
- Reset, then load RA=0x7FFF, RB=0x0001, then ADD → after edge k+1: RA_OUT=0x8000, RB_OUT=0x0001, N=1, Z=0, C=0, done pulse width 1.
- RA=0x0003, RB=0x0005, then SUB → RA=0xFFFE, C=1, N=1; then RA=5, RB=5, SUB → RA=0, Z=1, C=0.
- RA=0x8001, SHR by 4 → busy for 5 cycles, ins_ready=0 throughout, RA=0x0800, C=0, done 5 edges after accept; SAR by 4 on 0x8001 → 0xF800.
- EXCH with RA=0x1234, RB=0xABCD → RA=0xABCD, RB=0x1234; MOV next → RB=0xABCD.
- ld_a asserted with ins_valid in IDLE → ins_ready=0, RA loads, instruction is accepted the next cycle; ld_b during SHIFT → ld_err pulse, RB unchanged.
- Opcode 14 → done=1, illegal=1, RA/RB unchanged; reset asserted mid-SHL by 8 → next cycle IDLE, RA=0, no done.
